// File: rtl/uart_pkg.sv
// Shared state encoding and error codes for the UART receive-side frame controller.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } frame_state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/frame_buf.sv
// Payload buffer: DEPTH x 8 register array, one write port, one registered read port.
module frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind uart_rx: sync hunt, capture, checksum verify and
// replay of accepted payload over a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       uart_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    output logic [7:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    import uart_pkg::*;

    localparam int unsigned IDXW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

    frame_state_t    state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      sum_q, sum_d;
    logic [IDXW-1:0] len_q, len_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ridx_q, ridx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      out_addr_q, out_addr_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            frame_ok_q, frame_ok_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            busy_q;

    logic            buf_we;
    logic [7:0]      buf_rdata;
    logic [7:0]      sum_next;
    logic            in_frame;

    assign sum_next = sum_q + rx_data;
    assign in_frame = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);

    // Read address is the next-cycle beat index so the registered read lands
    // with the beat; it stays put while stalled, holding out_data.
    frame_buf #(
        .DEPTH(MAX_LEN),
        .AW   (AW)
    ) u_buf (
        .clk_i  (uart_clk),
        .rst_i  (reset),
        .we_i   (buf_we),
        .waddr_i(idx_q[AW-1:0]),
        .wdata_i(rx_data),
        .raddr_i(ridx_d[AW-1:0]),
        .rdata_o(buf_rdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        len_d       = len_q;
        idx_d       = idx_q;
        ridx_d      = ridx_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;
        tmo_d       = (rx_strobe || !in_frame) ? '0 : tmo_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (rx_strobe && rx_data == SYNC_BYTE) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_strobe) begin
                    addr_d  = rx_data;
                    sum_d   = rx_data;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_strobe) begin
                    sum_d = sum_next;
                    idx_d = '0;
                    len_d = rx_data[IDXW-1:0];
                    if (rx_data > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else if (rx_data == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_strobe) begin
                    buf_we = 1'b1;
                    sum_d  = sum_next;
                    idx_d  = idx_q + IDXW'(1);
                    if (idx_d == len_q) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (rx_strobe) begin
                    if (sum_next != 8'h00) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_ok_d = 1'b1;
                        if (len_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d     = ST_DRAIN;
                            ridx_d      = '0;
                            out_valid_d = 1'b1;
                            out_last_d  = (len_q == IDXW'(1));
                            out_addr_d  = addr_q;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_strobe) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (out_valid_q && out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        ridx_d     = ridx_q + IDXW'(1);
                        out_last_d = (ridx_d == len_q - IDXW'(1));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (in_frame && !rx_strobe && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            sum_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            ridx_q      <= '0;
            tmo_q       <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            ridx_q      <= ridx_d;
            tmo_q       <= tmo_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign out_addr  = out_addr_q;
    assign out_data  = buf_rdata;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frame-level reference model feeds
// expected events/beats into queues consumed by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

    localparam int MAXL = 16;
    localparam int TMO  = 200;
    localparam int EV_OK = 4;

    logic       uart_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_strobe = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_addr, out_data;
    logic       out_valid, out_last, frame_ok, frame_err, busy;
    logic [1:0] err_code;

    int checks = 0;
    int fails  = 0;
    int exp_ev[$];
    logic [16:0] exp_beat[$];
    int ready_mode = 0;

    bit         held_v = 1'b0;
    logic [7:0] held_data, held_addr;
    logic       held_last;

    uart_rx_frame_ctrl #(
        .SYNC_BYTE     (8'hA5),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .uart_clk (uart_clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_strobe(rx_strobe),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge uart_clk); #1;
        rx_data   = b;
        rx_strobe = 1'b1;
        @(posedge uart_clk); #1;
        rx_strobe = 1'b0;
    endtask

    task automatic gap(input int maxgap);
        repeat ($urandom_range(0, maxgap)) @(posedge uart_clk);
    endtask

    // Reference model: decides the frame's fate from the wire-format rule
    // (length limit, byte sum mod 256) and queues the expected outcome.
    task automatic send_frame(input logic [7:0] addr, input int len,
                              input logic [7:0] csum_delta, input int maxgap);
        logic [7:0] pl[$];
        logic [7:0] sum, cs, lb;
        lb  = 8'(len);
        sum = addr + lb;
        for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
            sum = sum + pl[i];
        end
        send_byte(8'hA5); gap(maxgap);
        send_byte(addr);  gap(maxgap);
        if (len > MAXL) begin
            exp_ev.push_back(1);
            send_byte(lb);
            return;
        end
        send_byte(lb);
        for (int i = 0; i < len; i++) begin
            gap(maxgap);
            send_byte(pl[i]);
        end
        cs = 8'(8'h00 - sum + csum_delta);
        gap(maxgap);
        if (8'(sum + cs) == 8'h00) begin
            exp_ev.push_back(EV_OK);
            for (int i = 0; i < len; i++) begin
                exp_beat.push_back({1'(i == len - 1), addr, pl[i]});
            end
        end else begin
            exp_ev.push_back(0);
        end
        send_byte(cs);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || out_valid || exp_beat.size() != 0) && n < 1000) begin
            @(posedge uart_clk); #1;
            n++;
        end
        chk({name, "_drain_bound"}, 32'(n < 1000), 1);
        repeat (2) @(posedge uart_clk);
        #1;
    endtask

    task automatic pop_ev(input string name, input int act);
        if (exp_ev.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: unexpected event %0d, expected none", name, act);
        end else begin
            chk(name, act, exp_ev.pop_front());
        end
    endtask

    initial forever begin
        @(posedge uart_clk); #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ~out_ready;
        endcase
    end

    always @(negedge uart_clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_hold", {out_valid, out_last, out_addr, out_data},
                    {1'b1, held_last, held_addr, held_data});
            end
            held_v    = out_valid && !out_ready;
            held_data = out_data;
            held_addr = out_addr;
            held_last = out_last;
            if (out_valid && out_ready) begin
                if (exp_beat.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL beat: unexpected beat %0h, expected none", out_data);
                end else begin
                    chk("beat", {out_last, out_addr, out_data}, exp_beat.pop_front());
                end
            end
            if (frame_ok)  pop_ev("event_ok", EV_OK);
            if (frame_err) pop_ev("event_err", int'(err_code));
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        logic [7:0] b;
        int n;

        repeat (3) @(posedge uart_clk);
        @(negedge uart_clk);
        chk("reset_outputs", {out_addr, out_data, out_valid, out_last, frame_ok, frame_err, err_code, busy}, 0);
        @(posedge uart_clk); #1;
        reset = 1'b0;

        // Good frame A5 10 03 01 02 03 E7
        exp_ev.push_back(EV_OK);
        exp_beat.push_back({1'b0, 8'h10, 8'h01});
        exp_beat.push_back({1'b0, 8'h10, 8'h02});
        exp_beat.push_back({1'b1, 8'h10, 8'h03});
        foreach (b_list_a[i]) send_byte(b_list_a[i]);
        chk("good_first_beat", {frame_ok, out_valid, out_addr, out_data, busy}, {1'b1, 1'b1, 8'h10, 8'h01, 1'b1});
        wait_idle("good");

        // Bad checksum, then a good frame is still accepted
        exp_ev.push_back(0);
        foreach (b_list_b[i]) send_byte(b_list_b[i]);
        chk("csum_err", {frame_err, err_code, out_valid, busy}, {1'b1, 2'd0, 1'b0, 1'b0});
        wait_idle("csum");
        send_frame(8'h44, 5, 8'h00, 2);
        wait_idle("after_csum");

        // Length above limit rejected on the LEN byte
        exp_ev.push_back(1);
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'd20);
        chk("len_err", {frame_err, err_code, busy}, {1'b1, 2'd1, 1'b0});
        repeat (3) @(posedge uart_clk);
        #1;
        chk("err_code_held", {frame_err, err_code}, {1'b0, 2'd1});

        // Timeout after 2 of 3 payload bytes
        exp_ev.push_back(2);
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
        n = 0;
        while (!frame_err && n < TMO + 10) begin
            @(posedge uart_clk); #1;
            n++;
        end
        chk("timeout_latency", n, TMO);
        chk("timeout_state", {err_code, busy}, {2'd2, 1'b0});
        wait_idle("timeout");

        // Stalled drain with an overrun byte in the middle
        ready_mode = 2;
        send_frame(8'h33, 3, 8'h00, 0);
        chk("drain_start", {frame_ok, out_valid}, 2'b11);
        exp_ev.push_back(3);
        send_byte(8'hA5);
        chk("overrun_err", {frame_err, err_code, busy}, {1'b1, 2'd3, 1'b1});
        wait_idle("overrun");
        ready_mode = 0;

        // SYNC strobe in the cycle the last beat is accepted is an overrun
        send_frame(8'h55, 1, 8'h00, 0);
        exp_ev.push_back(3);
        rx_data = 8'hA5;
        rx_strobe = 1'b1;
        @(posedge uart_clk); #1;
        rx_strobe = 1'b0;
        chk("last_beat_sync_lost", {frame_err, err_code, busy, out_valid}, {1'b1, 2'd3, 1'b0, 1'b0});
        wait_idle("lastsync");
        send_frame(8'h66, 2, 8'h00, 1);
        wait_idle("after_lastsync");

        // Reset mid-payload, then a zero-length frame
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h05); send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b1;
        repeat (2) begin
            @(negedge uart_clk);
            chk("reset_mid_frame", {out_valid, out_last, frame_ok, frame_err, err_code, busy, out_data, out_addr}, 0);
        end
        @(posedge uart_clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge uart_clk);
        #1;
        chk("no_pulse_after_reset", {frame_ok, frame_err, busy}, 0);
        exp_ev.push_back(EV_OK);
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'hF9);
        chk("zero_len_ok", {frame_ok, out_valid, busy}, {1'b1, 1'b0, 1'b0});
        wait_idle("zero_len");

        // Randomized frames with random back-pressure and line noise
        ready_mode = 1;
        repeat (40) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
            end
            send_frame(8'($urandom), $urandom_range(0, 20),
                       ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 4);
            wait_idle("random");
        end

        repeat (5) @(posedge uart_clk);
        #1;
        chk("events_consumed", exp_ev.size(), 0);
        chk("beats_consumed", exp_beat.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    logic [7:0] b_list_a [7] = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE7};
    logic [7:0] b_list_b [7] = '{8'hA5, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'hE8};

endmodule
